// File: rtl/som_sub_seq_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
package som_sub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of chunk cycles needed for one operation.
    function automatic int unsigned nch_f(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

    // Chunk-index register width; never zero so a single-chunk build still elaborates.
    function automatic int unsigned idx_w_f(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/som_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module som_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // Ripple chain of full-adder cells, LSB first.
    for (genvar b = 0; b < CHUNK; b++) begin : g_bit
        som_fa u_fa (
            .a  (x[b]),
            .b  (y[b]),
            .ci (c[b]),
            .s  (s[b]),
            .co (c[b+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/som_fa.sv
// One-bit full-adder cell, the ripple element of som_chunk.
module som_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/som_sub_seq.sv
// Multi-cycle add/subtract: CHUNK bits per clock with the ripple carry held in a flop between chunks.
module som_sub_seq
    import som_sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Cin,
    output logic [WIDTH-1:0] A,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCH   = nch_f(WIDTH, CHUNK);
    localparam int unsigned IDX_W = idx_w_f(NCH);

    // Reject chunk sizes that do not tile the word.
    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $error("som_sub_seq: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
    end
    if ((CHUNK >= 1) && (WIDTH % CHUNK != 0)) begin : g_bad_width
        $error("som_sub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    int unsigned        base_c;
    logic [CHUNK-1:0]   ch_x_c, ch_y_c, ch_s_c;
    logic               ch_co_c, ch_cmsb_c;
    logic               accept_c;

    // Select the chunk currently being processed.
    always_comb begin
        base_c = 32'(idx_q) * CHUNK;
        ch_x_c = x_q[base_c +: CHUNK];
        ch_y_c = y_q[base_c +: CHUNK];
    end

    som_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (ch_x_c),
        .y     (ch_y_c),
        .cin   (carry_q),
        .s     (ch_s_c),
        .cout  (ch_co_c),
        .c_msb (ch_cmsb_c)
    );

    // A new operation is accepted whenever the unit is not mid-calculation.
    assign accept_c = start && (state_q != ST_CALC);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        a_d     = a_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_CALC: begin
                busy_d             = 1'b1;
                a_d[base_c +: CHUNK] = ch_s_c;
                carry_d            = ch_co_c;
                idx_d              = IDX_W'(idx_q + 1'b1);
                if (idx_q == IDX_W'(NCH - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = ch_co_c;
                    ovf_d   = ch_cmsb_c ^ ch_co_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Subtraction is x + ~y + ~Cin; fold the inversion in at latch time.
        if (accept_c) begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
            idx_d   = '0;
            x_d     = x;
            y_d     = sub ? ~y : y;
            carry_d = sub ? ~Cin : Cin;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A    = a_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_som_sub_seq.sv
// Bench for som_sub_seq: three builds (CHUNK=4, 16, 1) at WIDTH=16 against an integer reference model.
module tb_som_sub_seq;

    logic        clk;
    logic        rst;
    logic        start_i [3];
    logic        sub_i   [3];
    logic [15:0] x_i     [3];
    logic [15:0] y_i     [3];
    logic        cin_i   [3];
    logic [15:0] a_o     [3];
    logic        cout_o  [3];
    logic        ovf_o   [3];
    logic        busy_o  [3];
    logic        done_o  [3];

    int tests_run;
    int tests_failed;
    int nch_tab [3] = '{4, 1, 16};

    som_sub_seq #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]), .x(x_i[0]), .y(y_i[0]),
        .Cin(cin_i[0]), .A(a_o[0]), .Cout(cout_o[0]), .Ovf(ovf_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );
    som_sub_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]), .x(x_i[1]), .y(y_i[1]),
        .Cin(cin_i[1]), .A(a_o[1]), .Cout(cout_o[1]), .Ovf(ovf_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );
    som_sub_seq #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]), .x(x_i[2]), .y(y_i[2]),
        .Cin(cin_i[2]), .A(a_o[2]), .Cout(cout_o[2]), .Ovf(ovf_o[2]), .busy(busy_o[2]), .done(done_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, returns {A, Cout, Ovf}.
    function automatic logic [17:0] ref_model(input logic s, input logic [15:0] xx, input logic [15:0] yy,
                                              input logic c);
        int ux, uy, sx, sy, ru, rs;
        logic co, ov;
        logic [31:0] rbits;
        ux = int'(xx);
        uy = int'(yy);
        sx = int'($signed(xx));
        sy = int'($signed(yy));
        if (!s) begin
            ru = ux + uy + int'(c);
            rs = sx + sy + int'(c);
            co = (ru > 65535);
        end else begin
            ru = ux - uy - int'(c);
            rs = sx - sy - int'(c);
            co = (ru >= 0);
        end
        ov    = (rs > 32767) || (rs < -32768);
        rbits = 32'(ru);
        return {rbits[15:0], co, ov};
    endfunction

    // Issue one operation on instance i and wait (bounded) for done; inputs are scrambled after acceptance.
    task automatic run_op(input int i, input logic s, input logic [15:0] xx, input logic [15:0] yy,
                          input logic c, output logic [17:0] res, output int lat, output int bcnt);
        @(posedge clk); #1;
        sub_i[i] = s; x_i[i] = xx; y_i[i] = yy; cin_i[i] = c; start_i[i] = 1'b1;
        lat = -1; bcnt = 0; res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start_i[i] = 1'b0;
                x_i[i] = 16'($urandom); y_i[i] = 16'($urandom);
                sub_i[i] = ~s; cin_i[i] = ~c;
            end
            if (busy_o[i]) bcnt++;
            if (done_o[i]) begin
                lat = n;
                res = {a_o[i], cout_o[i], ovf_o[i]};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({a_o[i], cout_o[i], ovf_o[i], busy_o[i], done_o[i]} !== 20'h0) begin
                tests_failed++;
                $display("FAIL reset inst%0d: got A=%h Cout=%b Ovf=%b busy=%b done=%b, want all zero",
                         i, a_o[i], cout_o[i], ovf_o[i], busy_o[i], done_o[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic        vs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] vx   [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
        logic [15:0] vy   [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
        logic        vc   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [17:0] vexp [6] = '{{16'h5555, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
                                  {16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}, {16'h000E, 2'b10}};
        logic [17:0] res;
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 6; v++) begin
                run_op(i, vs[v], vx[v], vy[v], vc[v], res, lat, bcnt);
                tests_run++;
                if (res !== vexp[v]) begin
                    tests_failed++;
                    $display("FAIL directed inst%0d vec%0d: got {A,Cout,Ovf}=%h want %h", i, v, res, vexp[v]);
                end
                tests_run++;
                if (lat !== nch_tab[i] + 1 || bcnt !== nch_tab[i]) begin
                    tests_failed++;
                    $display("FAIL directed_timing inst%0d vec%0d: got latency=%0d busy=%0d want %0d/%0d",
                             i, v, lat, bcnt, nch_tab[i] + 1, nch_tab[i]);
                end
            end
        end
    endtask

    task automatic test_hold_after_done();
        logic [17:0] res, held;
        int lat, bcnt;
        run_op(0, 1'b0, 16'h0F0F, 16'h1010, 1'b1, res, lat, bcnt);
        repeat (3) @(posedge clk);
        #1;
        held = {a_o[0], cout_o[0], ovf_o[0]};
        tests_run++;
        if (held !== {16'h1F20, 2'b00} || done_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold: got {A,Cout,Ovf}=%h done=%b want %h done=0", held, done_o[0], {16'h1F20, 2'b00});
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [17:0] res;
        @(posedge clk); #1;
        sub_i[0] = 1'b0; x_i[0] = 16'h1111; y_i[0] = 16'h2222; cin_i[0] = 1'b0; start_i[0] = 1'b1;
        lat = -1; res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) start_i[0] = 1'b0;
            if (n == 2) begin
                start_i[0] = 1'b1; sub_i[0] = 1'b1; x_i[0] = 16'hABCD; y_i[0] = 16'h0123; cin_i[0] = 1'b1;
            end
            if (n == 3) start_i[0] = 1'b0;
            if (done_o[0]) begin
                lat = n;
                res = {a_o[0], cout_o[0], ovf_o[0]};
                break;
            end
        end
        tests_run++;
        if (res !== {16'h3333, 2'b00} || lat !== 5) begin
            tests_failed++;
            $display("FAIL start_ignored: got {A,Cout,Ovf}=%h latency=%0d want %h latency=5",
                     res, lat, {16'h3333, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        logic [17:0] res;
        logic acc;
        @(posedge clk); #1;
        sub_i[0] = 1'b0; x_i[0] = 16'h1234; y_i[0] = 16'h4321; cin_i[0] = 1'b0; start_i[0] = 1'b1;
        lat = -1; res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_o[0]) begin
                lat = n;
                res = {a_o[0], cout_o[0], ovf_o[0]};
                break;
            end
        end
        tests_run++;
        if (res !== {16'h5555, 2'b00} || lat !== 5) begin
            tests_failed++;
            $display("FAIL b2b_first: got {A,Cout,Ovf}=%h latency=%0d want %h latency=5", res, lat, {16'h5555, 2'b00});
        end
        // Start still high in the done cycle; present the second operation now.
        sub_i[0] = 1'b1; x_i[0] = 16'h8000; y_i[0] = 16'h0001; cin_i[0] = 1'b0;
        lat2 = -1; res = '0; acc = 1'b0;
        for (int m = 1; m <= 40; m++) begin
            @(posedge clk); #1;
            if (m == 1) begin
                acc = busy_o[0];
                start_i[0] = 1'b0;
            end
            if (done_o[0]) begin
                lat2 = m;
                res = {a_o[0], cout_o[0], ovf_o[0]};
                break;
            end
        end
        tests_run++;
        if (res !== {16'h7FFF, 2'b11} || lat2 !== 5 || acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: got {A,Cout,Ovf}=%h gap=%0d accepted=%b want %h gap=5 accepted=1",
                     res, lat2, acc, {16'h7FFF, 2'b11});
        end
    endtask

    task automatic test_reset_abort();
        int dones, lat, bcnt;
        logic [17:0] res;
        @(posedge clk); #1;
        sub_i[0] = 1'b0; x_i[0] = 16'hFFFF; y_i[0] = 16'hFFFF; cin_i[0] = 1'b1; start_i[0] = 1'b1;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({a_o[0], cout_o[0], ovf_o[0], busy_o[0], done_o[0]} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_abort: got A=%h Cout=%b Ovf=%b busy=%b done=%b want all zero",
                     a_o[0], cout_o[0], ovf_o[0], busy_o[0], done_o[0]);
        end
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done_o[0] || busy_o[0]) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d active cycles after abort want 0", dones);
        end
        run_op(0, 1'b1, 16'h0100, 16'h0001, 1'b0, res, lat, bcnt);
        tests_run++;
        if (res !== {16'h00FF, 2'b10} || lat !== 5) begin
            tests_failed++;
            $display("FAIL reset_recover: got {A,Cout,Ovf}=%h latency=%0d want %h latency=5",
                     res, lat, {16'h00FF, 2'b10});
        end
    endtask

    task automatic test_random();
        logic [17:0] res, exp;
        logic s, c;
        logic [15:0] xx, yy;
        int lat, bcnt, cnt;
        for (int i = 0; i < 3; i++) begin
            cnt = (i == 0) ? 200 : 1000;
            for (int k = 0; k < cnt; k++) begin
                s  = 1'($urandom);
                c  = 1'($urandom);
                xx = 16'($urandom);
                yy = 16'($urandom);
                if (k % 8 == 0) xx = 16'h7FFF ^ 16'($urandom_range(0, 3));
                if (k % 8 == 1) yy = 16'h8000 | 16'($urandom_range(0, 3));
                exp = ref_model(s, xx, yy, c);
                run_op(i, s, xx, yy, c, res, lat, bcnt);
                tests_run++;
                if (res !== exp || lat !== nch_tab[i] + 1) begin
                    tests_failed++;
                    $display("FAIL random inst%0d sub=%b x=%h y=%h cin=%b: got {A,Cout,Ovf}=%h lat=%0d want %h lat=%0d",
                             i, s, xx, yy, c, res, lat, exp, nch_tab[i] + 1);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0; sub_i[i] = 1'b0; x_i[i] = '0; y_i[i] = '0; cin_i[i] = 1'b0;
        end
        test_reset();
        test_directed();
        test_hold_after_done();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
